// File: rtl/button_press_classifier_pkg.sv
// Shared types and default board timing for the push-button classifier.
// State codes are fixed constants so older tools and logic analysers see stable values.
package btn_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRESSED  = 3'd1;
    localparam logic [2:0] ST_WAIT_GAP = 3'd2;
    localparam logic [2:0] ST_SECOND   = 3'd3;
    localparam logic [2:0] ST_HELD     = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        PRESSED  = ST_PRESSED,
        WAIT_GAP = ST_WAIT_GAP,
        SECOND   = ST_SECOND,
        HELD     = ST_HELD
    } btn_state_t;

    // 50 MHz board: 1 s long press, 250 ms double-press window.
    localparam int unsigned DEF_LONG_CYCLES = 50_000_000;
    localparam int unsigned DEF_GAP_CYCLES  = 12_500_000;
    localparam int unsigned DEF_CNT_W       = 26;

endpackage

// File: rtl/button_press_classifier_if.sv
// Button level in, classified one-cycle events and status levels out.
interface button_press_classifier_if;

    logic pb_level;
    logic short_press;
    logic double_press;
    logic long_press;
    logic held;
    logic busy;

    modport master (
        output pb_level,
        input  short_press, double_press, long_press, held, busy
    );

    modport slave (
        input  pb_level,
        output short_press, double_press, long_press, held, busy
    );

endinterface

// File: rtl/button_press_classifier_pb_edge_detect.sv
// Registered edge detector for an already-synchronous level.
// The register resets to 1 so a level held through reset never produces a rise.
module pb_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b1;
        end else begin
            r_q <= d;
        end
    end

    assign rise = d & ~r_q;
    assign fall = ~d & r_q;
    assign q    = r_q;

endmodule

// File: rtl/button_press_classifier.sv
// Classifies a debounced button level into short, double and long press pulses.
// All outputs are registered; pulses appear the cycle after the deciding edge.
module button_press_classifier
    import btn_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    button_press_classifier_if.slave  bus
);

    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYCLES - 1);

    logic             w_rise;
    logic             w_fall;
    logic             w_pb_q_unused;
    btn_state_t       r_state;
    btn_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_short;
    logic             w_double;
    logic             w_long;
    logic             r_short;
    logic             r_double;
    logic             r_long;
    logic             r_held;
    logic             r_busy;

    pb_edge_detect u_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.pb_level),
        .rise (w_rise),
        .fall (w_fall),
        .q    (w_pb_q_unused)
    );

    // A rise on the window's terminal cycle takes priority over the short press.
    always_comb begin
        w_next   = r_state;
        w_short  = 1'b0;
        w_double = 1'b0;
        w_long   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) w_next = PRESSED;
            end
            PRESSED: begin
                if (bus.pb_level && (r_cnt == LONG_TC)) begin
                    w_next = HELD;
                    w_long = 1'b1;
                end else if (w_fall) begin
                    w_next = WAIT_GAP;
                end
            end
            WAIT_GAP: begin
                if (w_rise) begin
                    w_next = SECOND;
                end else if (r_cnt == GAP_TC) begin
                    w_next  = IDLE;
                    w_short = 1'b1;
                end
            end
            SECOND: begin
                if (w_fall) begin
                    w_next   = IDLE;
                    w_double = 1'b1;
                end else if (bus.pb_level && (r_cnt == LONG_TC)) begin
                    w_next = HELD;
                    w_long = 1'b1;
                end
            end
            HELD: begin
                if (w_fall) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_held   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_short  <= w_short;
            r_double <= w_double;
            r_long   <= w_long;
            r_held   <= (w_next == HELD);
            r_busy   <= (w_next != IDLE);
            // Terminal counts always force a transition, so the counter never wraps.
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == PRESSED) || (r_state == WAIT_GAP) || (r_state == SECOND)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.short_press  = r_short;
    assign bus.double_press = r_double;
    assign bus.long_press   = r_long;
    assign bus.held         = r_held;
    assign bus.busy         = r_busy;

endmodule
